bram_switch_nch: RTL and testbench
==================================

BRAM_SWITCH_NCH -- requirements
Module: bram_switch_nch

Interface
REQ-001 SHALL have parameter NCH, default 4, number of slave BRAM ports (legal 2..8).
REQ-002 SHALL have parameter BRAMDATA_WIDTH, default 64, data width (multiple of 8).
REQ-003 SHALL have parameter BRAMADDR_WIDTH, default 18, address width.
REQ-004 SHALL have parameters ENABLE_INPUT_REGISTER and ENABLE_OUTPUT_REGISTER, default 1 each, pipeline stage enables (0/1).
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock, all logic on rising edge; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have the following slave ports (channel k occupies slice k):
- s_addra  in  NCH*BRAMADDR_WIDTH  slave addresses.
- s_dina  in  NCH*BRAMDATA_WIDTH  slave write data.
- s_ena  in  NCH  slave enables.
- s_wea  in  NCH*BRAMDATA_WIDTH/8  slave byte write enables.
- s_douta  out  NCH*BRAMDATA_WIDTH  slave read data.
REQ-007 SHALL have the following master ports:
- m_addra  out  BRAMADDR_WIDTH  master address.
- m_dina  out  BRAMDATA_WIDTH  master write data.
- m_ena  out  1  master enable.
- m_wea  out  BRAMDATA_WIDTH/8  master byte write enable.
- m_douta  in  BRAMDATA_WIDTH  master read data.
REQ-008 SHALL have the following control and status ports:
- bram_select  in  4  0 = none; k in 1..NCH = channel k-1; >NCH = none.
- active_ch  out  4  currently connected channel code, same encoding.
- switching  out  1  high while draining.
- wr_count  out  32  writes forwarded since last connect (only with macro).

Function
REQ-009 SHALL implement FSM IDLE (no channel connected), ACTIVE (active_ch connected), DRAIN (master gated).
REQ-010 SHALL compute LAT = ENABLE_INPUT_REGISTER + ENABLE_OUTPUT_REGISTER; slave-to-master forward latency SHALL be exactly LAT cycles.
REQ-011 IDLE: legal nonzero bram_select -> ACTIVE next cycle, active_ch <= bram_select.
REQ-012 ACTIVE: bram_select != active_ch -> DRAIN, loading drain counter with LAT+1.
REQ-013 DRAIN: m_ena, m_wea forced 0 at outputs; slave inputs ignored; counter decrements each cycle.
REQ-014 DRAIN counter reaching 0: latest bram_select legal nonzero -> ACTIVE with that channel, else IDLE.
REQ-015 Select changes during DRAIN SHALL NOT restart the counter; only the value sampled at exit counts.
REQ-016 IDLE/DRAIN: m_addra, m_dina = 0 and m_ena, m_wea = 0.
REQ-017 Read return: s_douta slice of active_ch = m_douta (combinational); all other slices and all slices in IDLE/DRAIN = 0.
REQ-018 Unselected channels' s_ena/s_wea SHALL have no effect on the master.
REQ-019 switching = 1 exactly in DRAIN.
REQ-020 Out-of-range bram_select (>NCH) SHALL be treated as 0.

Reset
REQ-021 rst SHALL force IDLE, active_ch=0, switching=0, drain counter 0, all pipeline registers 0, m_* outputs 0, wr_count 0.
REQ-022 rst asserted mid-ACTIVE or mid-DRAIN SHALL discard in-flight pipeline contents; no write issues after rst.
REQ-023 After release, FSM SHALL sample bram_select on the first non-reset edge.

Configuration
REQ-024 Macro BRAM_SWITCH_WRCNT_EN SHALL gate the write counter.
REQ-025 With the macro: wr_count increments on each cycle m_ena=1 and m_wea!=0, saturates at 0xFFFFFFFF, clears on entering ACTIVE.
REQ-026 Without the macro: wr_count port absent, no counter logic.

Structure
REQ-027 Package bram_switch_pkg SHALL hold FSM state typedef (IDLE/ACTIVE/DRAIN), select width constant (4), and NONE code constant (0).
REQ-028 One sub-module bram_switch_pipe (parametrised register stage, bypassed when its enable is 0) SHALL be instantiated for input and output stages.

Verification
REQ-029 NCH=4, LAT=2, select=1, ch0 writes addr=n, data=n each cycle -> m_addra/m_dina = n two cycles later; m_douta routed to s_douta slice 0 only.
REQ-030 Select 1->3 while ch0 writes -> switching high 3 cycles, m_ena=0 meanwhile, first ch2 write appears on master 2 cycles after ACTIVE.
REQ-031 Select 1->2->4 inside DRAIN -> single drain of 3 cycles, ends ACTIVE with active_ch=4.
REQ-032 Select=7 (>NCH) from IDLE -> stays IDLE, m_* all 0.
REQ-033 rst pulse mid-DRAIN -> next cycle IDLE, active_ch=0, switching=0, no master write.
REQ-034 With BRAM_SWITCH_WRCNT_EN, 100 ch0 writes then reselect ch1 -> wr_count=100 before drain, 0 on entering ACTIVE.

Source files
------------

// File: rtl/bram_switch_pkg.sv
// Shared types and constants for the N-channel BRAM port switch.
// Holds the FSM state type, select code width and the "no channel" code.
package bram_switch_pkg;

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_NONE = '0;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_e;

  // Select codes above the channel count mean "no channel".
  function automatic logic [SEL_W-1:0] sel_norm(
    input logic [SEL_W-1:0] sel,
    input int               nch
  );
    return (int'(sel) > nch) ? SEL_NONE : sel;
  endfunction

endpackage

// File: rtl/bram_switch_pipe.sv
// Optional single register stage; a plain wire when EN is 0.
// Ports: clk, rst (sync, active-high), d_i stage input, q_o stage output.
module bram_switch_pipe #(
  parameter int W  = 1,
  parameter int EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (EN != 0) begin : g_reg
      logic [W-1:0] q_q;
      always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= d_i;
      end
      assign q_o = q_q;
    end else begin : g_byp
      logic unused_ctl;
      assign unused_ctl = clk ^ rst;
      assign q_o = d_i;
    end
  endgenerate

endmodule

// File: rtl/bram_switch_nch.sv
// Connects one of NCH slave BRAM ports to a single master BRAM port.
// On a reselect the master is gated for LAT+1 cycles so in-flight
// accesses from the old channel never reach the memory.
// Ports: s_* slave channels (slice k = channel k), m_* master port,
// bram_select (0/>NCH = none, k = channel k-1), active_ch, switching.
// Optional macro BRAM_SWITCH_WRCNT_EN adds wr_count (forwarded writes
// since the last connect, saturating).
module bram_switch_nch
  import bram_switch_pkg::*;
#(
  parameter int NCH                    = 4,
  parameter int BRAMDATA_WIDTH         = 64,
  parameter int BRAMADDR_WIDTH         = 18,
  parameter int ENABLE_INPUT_REGISTER  = 1,
  parameter int ENABLE_OUTPUT_REGISTER = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH*BRAMADDR_WIDTH-1:0] s_addra,
  input  logic [NCH*BRAMDATA_WIDTH-1:0] s_dina,
  input  logic [NCH-1:0]                s_ena,
  input  logic [NCH*BRAMDATA_WIDTH/8-1:0] s_wea,
  output logic [NCH*BRAMDATA_WIDTH-1:0] s_douta,
  output logic [BRAMADDR_WIDTH-1:0]     m_addra,
  output logic [BRAMDATA_WIDTH-1:0]     m_dina,
  output logic                          m_ena,
  output logic [BRAMDATA_WIDTH/8-1:0]   m_wea,
  input  logic [BRAMDATA_WIDTH-1:0]     m_douta,
  input  logic [SEL_W-1:0]              bram_select,
  output logic [SEL_W-1:0]              active_ch,
  output logic                          switching
`ifdef BRAM_SWITCH_WRCNT_EN
  ,
  output logic [31:0]                   wr_count
`endif
);

  localparam int AW  = BRAMADDR_WIDTH;
  localparam int DW  = BRAMDATA_WIDTH;
  localparam int BW  = BRAMDATA_WIDTH / 8;
  localparam int PW  = AW + DW + 1 + BW;
  localparam int LAT = ENABLE_INPUT_REGISTER + ENABLE_OUTPUT_REGISTER;
  localparam logic [1:0] DRAIN_LD = 2'(LAT + 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] act_q, act_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_n;
  logic [PW-1:0]    feed, mid, pout;
  logic             live;

  assign sel_n = sel_norm(bram_select, NCH);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_n != SEL_NONE) begin
          state_d = ACTIVE;
          act_d   = sel_n;
        end
      end
      ACTIVE: begin
        if (sel_n != act_q) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 2'd1;
        // Only the select seen on the final drain cycle matters.
        if (cnt_q <= 2'd1) begin
          cnt_d = '0;
          if (sel_n != SEL_NONE) begin
            state_d = ACTIVE;
            act_d   = sel_n;
          end else begin
            state_d = IDLE;
            act_d   = SEL_NONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        act_d   = SEL_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= SEL_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the connected channel feeds the pipe; zeros otherwise.
  always_comb begin
    feed = '0;
    for (int k = 0; k < NCH; k++) begin
      if (state_q == ACTIVE && act_q == SEL_W'(k + 1)) begin
        feed = {s_addra[k*AW +: AW], s_dina[k*DW +: DW],
                s_ena[k], s_wea[k*BW +: BW]};
      end
    end
  end

  bram_switch_pipe #(
    .W  (PW),
    .EN (ENABLE_INPUT_REGISTER)
  ) u_in (
    .clk (clk),
    .rst (rst),
    .d_i (feed),
    .q_o (mid)
  );

  bram_switch_pipe #(
    .W  (PW),
    .EN (ENABLE_OUTPUT_REGISTER)
  ) u_out (
    .clk (clk),
    .rst (rst),
    .d_i (mid),
    .q_o (pout)
  );

  assign live    = (state_q == ACTIVE);
  assign m_addra = live ? pout[PW-1 -: AW] : '0;
  assign m_dina  = live ? pout[BW+1 +: DW] : '0;
  assign m_ena   = live & pout[BW];
  assign m_wea   = live ? pout[BW-1:0] : '0;

  always_comb begin
    s_douta = '0;
    for (int k = 0; k < NCH; k++) begin
      if (live && act_q == SEL_W'(k + 1)) begin
        s_douta[k*DW +: DW] = m_douta;
      end
    end
  end

  assign active_ch = act_q;
  assign switching = (state_q == DRAIN);

`ifdef BRAM_SWITCH_WRCNT_EN
  logic [31:0] wr_q, wr_d;

  always_comb begin
    wr_d = wr_q;
    if (state_d == ACTIVE && state_q != ACTIVE) begin
      wr_d = '0;
    end else if (m_ena && (|m_wea) && wr_q != '1) begin
      wr_d = wr_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_q <= '0;
    else     wr_q <= wr_d;
  end

  assign wr_count = wr_q;
`endif

endmodule

// File: tb/tb_bram_switch_nch.sv
// Directed, table-driven bench for bram_switch_nch (NCH=4, LAT=2).
// Slave channel k drives addr {k+1,n}, data {k+1,n} on cycle n.
module tb_bram_switch_nch;

  logic         clk;
  logic         rst;
  logic [71:0]  s_addra;
  logic [255:0] s_dina;
  logic [3:0]   s_ena;
  logic [31:0]  s_wea;
  logic [255:0] s_douta;
  logic [17:0]  m_addra;
  logic [63:0]  m_dina;
  logic         m_ena;
  logic [7:0]   m_wea;
  logic [63:0]  m_douta;
  logic [3:0]   bram_select;
  logic [3:0]   active_ch;
  logic         switching;
`ifdef BRAM_SWITCH_WRCNT_EN
  logic [31:0]  wr_count;
`endif

  int checks = 0;
  int errors = 0;

  bram_switch_nch dut (
    .clk         (clk),
    .rst         (rst),
    .s_addra     (s_addra),
    .s_dina      (s_dina),
    .s_ena       (s_ena),
    .s_wea       (s_wea),
    .s_douta     (s_douta),
    .m_addra     (m_addra),
    .m_dina      (m_dina),
    .m_ena       (m_ena),
    .m_wea       (m_wea),
    .m_douta     (m_douta),
    .bram_select (bram_select),
    .active_ch   (active_ch),
    .switching   (switching)
`ifdef BRAM_SWITCH_WRCNT_EN
    ,
    .wr_count    (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // act = 4'hF: active_ch not compared on that row.
  typedef struct {
    logic [3:0] sel;
    logic [3:0] en;
    logic [3:0] act;
    logic       sw;
    logic [3:0] src;
    int         n;
    logic       ena;
    logic [3:0] rd;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic [3:0] sel, input logic [3:0] en,
                              input logic [3:0] act, input logic sw,
                              input logic [3:0] src, input int n,
                              input logic ena, input logic [3:0] rd);
    vec_t v;
    v.sel = sel; v.en = en; v.act = act; v.sw = sw;
    v.src = src; v.n = n; v.ena = ena; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] en, input int n);
    for (int k = 0; k < 4; k++) begin
      s_addra[k*18 +: 18] = {4'(k + 1), 14'(n)};
      s_dina[k*64 +: 64]  = {32'(k + 1), 32'(n)};
      s_ena[k]            = en[k];
      s_wea[k*8 +: 8]     = en[k] ? {4'(k + 1), 4'(k + 1)} : 8'h00;
    end
  endtask

  function automatic logic [255:0] exp_rd(input logic [3:0] rd,
                                          input logic [63:0] md);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (rd == 4'(k + 1)) v[k*64 +: 64] = md;
    end
    return v;
  endfunction

  initial begin
    //        sel    en     act    sw src n   ena rd
    tbl[0]  = mk(4'd1, 4'hF, 4'd1, 0, 0, 0,  0, 1);
    tbl[1]  = mk(4'd1, 4'hF, 4'd1, 0, 0, 0,  0, 1);
    tbl[2]  = mk(4'd1, 4'hF, 4'd1, 0, 1, 1,  1, 1);
    tbl[3]  = mk(4'd1, 4'hF, 4'd1, 0, 1, 2,  1, 1);
    tbl[4]  = mk(4'd3, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[5]  = mk(4'd3, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[6]  = mk(4'd3, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[7]  = mk(4'd3, 4'hF, 4'd3, 0, 0, 0,  0, 3);
    tbl[8]  = mk(4'd3, 4'hF, 4'd3, 0, 0, 0,  0, 3);
    tbl[9]  = mk(4'd3, 4'hF, 4'd3, 0, 3, 8,  1, 3);
    tbl[10] = mk(4'd2, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[11] = mk(4'd2, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[12] = mk(4'd4, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[13] = mk(4'd4, 4'hF, 4'd4, 0, 0, 0,  0, 4);
    tbl[14] = mk(4'd4, 4'hF, 4'd4, 0, 0, 0,  0, 4);
    tbl[15] = mk(4'd4, 4'hF, 4'd4, 0, 4, 14, 1, 4);
    tbl[16] = mk(4'd0, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[17] = mk(4'd7, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[18] = mk(4'd7, 4'hF, 4'hF, 1, 0, 0,  0, 0);
    tbl[19] = mk(4'd7, 4'hF, 4'd0, 0, 0, 0,  0, 0);
    tbl[20] = mk(4'd7, 4'hF, 4'd0, 0, 0, 0,  0, 0);
    tbl[21] = mk(4'd5, 4'hF, 4'd0, 0, 0, 0,  0, 0);
    tbl[22] = mk(4'd2, 4'hF, 4'd2, 0, 0, 0,  0, 2);
    tbl[23] = mk(4'd2, 4'hF, 4'd2, 0, 0, 0,  0, 2);
    tbl[24] = mk(4'd2, 4'hF, 4'd2, 0, 2, 23, 1, 2);
    tbl[25] = mk(4'd2, 4'hD, 4'd2, 0, 2, 24, 1, 2);
    tbl[26] = mk(4'd2, 4'hF, 4'd2, 0, 2, 25, 0, 2);
    tbl[27] = mk(4'd2, 4'hF, 4'd2, 0, 2, 26, 1, 2);

    rst = 1'b1;
    bram_select = '0;
    m_douta = '0;
    drive(4'h0, 0);
    tick();
    tick();
    chk("rst active_ch", 256'(active_ch), 256'(0));
    chk("rst switching", 256'(switching), 256'(0));
    chk("rst m_ena", 256'(m_ena), 256'(0));
    chk("rst m_addra", 256'(m_addra), 256'(0));
    chk("rst s_douta", s_douta, 256'(0));
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      logic [17:0] ea;
      logic [63:0] ed;
      logic [7:0]  ew;
      bram_select = tbl[i].sel;
      drive(tbl[i].en, i);
      m_douta = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      tick();
      ea = (tbl[i].src == 0) ? 18'h0 : {tbl[i].src, 14'(tbl[i].n)};
      ed = (tbl[i].src == 0) ? 64'h0 : {32'(tbl[i].src), 32'(tbl[i].n)};
      ew = tbl[i].ena ? {tbl[i].src, tbl[i].src} : 8'h00;
      if (tbl[i].act != 4'hF)
        chk($sformatf("row%0d active_ch", i), 256'(active_ch),
            256'(tbl[i].act));
      chk($sformatf("row%0d switching", i), 256'(switching),
          256'(tbl[i].sw));
      chk($sformatf("row%0d m_ena", i), 256'(m_ena), 256'(tbl[i].ena));
      chk($sformatf("row%0d m_wea", i), 256'(m_wea), 256'(ew));
      chk($sformatf("row%0d m_addra", i), 256'(m_addra), 256'(ea));
      chk($sformatf("row%0d m_dina", i), 256'(m_dina), 256'(ed));
      chk($sformatf("row%0d s_douta", i), s_douta,
          exp_rd(tbl[i].rd, m_douta));
    end

    // Reset while draining: everything cleared, no later write.
    bram_select = 4'd1;
    drive(4'hF, 100);
    tick();
    chk("rd drain sw", 256'(switching), 256'(1));
    rst = 1'b1;
    tick();
    chk("rd active_ch", 256'(active_ch), 256'(0));
    chk("rd switching", 256'(switching), 256'(0));
    chk("rd m_ena", 256'(m_ena), 256'(0));
    rst = 1'b0;
    bram_select = 4'd0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rd post%0d m_ena", j), 256'(m_ena), 256'(0));
      chk($sformatf("rd post%0d sw", j), 256'(switching), 256'(0));
    end

    // Reset while active with writes in flight.
    bram_select = 4'd1;
    tick();
    chk("ra connect", 256'(active_ch), 256'(1));
    tick();
    chk("ra first m_ena", 256'(m_ena), 256'(0));
    tick();
    chk("ra write m_ena", 256'(m_ena), 256'(1));
    rst = 1'b1;
    tick();
    chk("ra rst m_ena", 256'(m_ena), 256'(0));
    chk("ra rst active_ch", 256'(active_ch), 256'(0));
    rst = 1'b0;
    tick();
    chk("ra resample active_ch", 256'(active_ch), 256'(1));
    chk("ra flushed0 m_ena", 256'(m_ena), 256'(0));
    tick();
    chk("ra flushed1 m_ena", 256'(m_ena), 256'(0));

`ifdef BRAM_SWITCH_WRCNT_EN
    rst = 1'b1;
    bram_select = 4'd1;
    drive(4'h0, 0);
    tick();
    rst = 1'b0;
    tick();
    for (int j = 0; j < 100; j++) begin
      drive(4'h1, j);
      tick();
    end
    drive(4'h0, 0);
    tick();
    tick();
    tick();
    chk("wr_count before drain", 256'(wr_count), 256'(100));
    bram_select = 4'd2;
    tick();
    tick();
    tick();
    tick();
    chk("wr_count after reconnect", 256'(wr_count), 256'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
